fpga_bridge_vc_send: RTL and testbench

//  Parametrised single-clock sender for the FPGA<->chip bridge. Takes NUM_CH val/rdy NoC

---
 rtl/fpga_bridge_vc_send.sv | 130 +++++++++++++
 tb/tb_fpga_bridge_vc_send.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_bridge_vc_send.sv
// Multi-channel bridge sender: round-robin arbitration over credit-controlled NoC channels,
// serialising each granted flit LSB-first onto a PHY_WIDTH link tagged with its channel id.
module fpga_bridge_vc_send #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned PHY_WIDTH  = 32,
    parameter int unsigned CREDIT_MAX = 255,
    parameter int unsigned CNT_W      = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         link_en,
    input  logic [NUM_CH*FLIT_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_val,
    output logic [NUM_CH-1:0]            in_rdy,
    output logic [PHY_WIDTH-1:0]         link_data,
    output logic                         link_val,
    output logic [CH_W-1:0]              link_channel,
    input  logic [NUM_CH-1:0]            link_credit,
    output logic [NUM_CH-1:0]            credit_zero,
    output logic [NUM_CH-1:0]            credit_ovf
);

    localparam int unsigned BEATS  = FLIT_WIDTH / PHY_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_nxt;
    logic [BEAT_W-1:0]       beat_idx;
    logic [FLIT_WIDTH-1:0]   flit_q;
    logic [FLIT_WIDTH-1:0]   sel_flit;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         gnt_ch;
    logic [CH_W-1:0]         srch_idx;
    logic                    gnt_any;
    logic                    last_beat;
    logic                    accept_ok;
    logic                    accept;
    logic [NUM_CH-1:0]       eligible;

    assign last_beat = (state == SEND) && (beat_idx == BEAT_W'(BEATS - 1));
    assign accept_ok = !rst && link_en && ((state == IDLE) || last_beat);
    assign accept    = accept_ok && gnt_any;
    assign sel_flit  = in_data[gnt_ch*FLIT_WIDTH +: FLIT_WIDTH];

    // Round robin: first eligible channel after the last granted one, with wrap
    always_comb begin
        gnt_any  = 1'b0;
        gnt_ch   = '0;
        srch_idx = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            srch_idx = CH_W'((int'(rr_ptr) + k) % int'(NUM_CH));
            if (!gnt_any && eligible[srch_idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = srch_idx;
            end
        end
    end

    always_comb begin
        in_rdy = '0;
        if (accept) in_rdy[gnt_ch] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (last_beat && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Link beat register; link_data deliberately holds its last value when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_val     <= 1'b0;
            link_data    <= '0;
            link_channel <= '0;
            flit_q       <= '0;
            beat_idx     <= '0;
            rr_ptr       <= CH_W'(NUM_CH - 1);
        end else if (accept) begin
            link_val     <= 1'b1;
            link_data    <= sel_flit[PHY_WIDTH-1:0];
            link_channel <= gnt_ch;
            flit_q       <= sel_flit >> PHY_WIDTH;
            beat_idx     <= '0;
            rr_ptr       <= gnt_ch;
        end else if ((state == SEND) && !last_beat) begin
            link_data    <= flit_q[PHY_WIDTH-1:0];
            flit_q       <= flit_q >> PHY_WIDTH;
            beat_idx     <= beat_idx + 1'b1;
        end else begin
            link_val     <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_credit
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             take;

        assign take           = accept && (gnt_ch == CH_W'(i));
        assign eligible[i]    = in_val[i] && (cnt != '0);
        assign credit_zero[i] = (cnt == '0);
        assign credit_ovf[i]  = ovf;

        // Simultaneous take and return cancel; a return at full credit flags overflow
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= CNT_W'(CREDIT_MAX);
                ovf <= 1'b0;
            end else if (take && !link_credit[i]) begin
                cnt <= cnt - 1'b1;
            end else if (!take && link_credit[i]) begin
                if (cnt == CNT_W'(CREDIT_MAX)) ovf <= 1'b1;
                else                           cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpga_bridge_vc_send.sv
// Bench for fpga_bridge_vc_send: directed scenarios plus random traffic, checked against a
// beat-queue reference model of credits, round-robin grants and link serialisation.
module tb_fpga_bridge_vc_send;

    localparam int NUM_CH = 3;
    localparam int FW     = 64;
    localparam int PW     = 32;
    localparam int CMAX   = 255;
    localparam int BEATS  = FW / PW;

    logic                    clk;
    logic                    rst;
    logic                    link_en;
    logic [NUM_CH*FW-1:0]    in_data;
    logic [NUM_CH-1:0]       in_val;
    logic [NUM_CH-1:0]       in_rdy;
    logic [PW-1:0]           link_data;
    logic                    link_val;
    logic [1:0]              link_channel;
    logic [NUM_CH-1:0]       link_credit;
    logic [NUM_CH-1:0]       credit_zero;
    logic [NUM_CH-1:0]       credit_ovf;

    fpga_bridge_vc_send dut (
        .clk          (clk),
        .rst          (rst),
        .link_en      (link_en),
        .in_data      (in_data),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .link_data    (link_data),
        .link_val     (link_val),
        .link_channel (link_channel),
        .link_credit  (link_credit),
        .credit_zero  (credit_zero),
        .credit_ovf   (credit_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;

    // Reference model state
    int          credit [NUM_CH];
    logic [2:0]  ovf_m;
    int          rr;
    logic [31:0] qd [$];
    logic [1:0]  qc [$];
    logic        cur_val;
    logic [31:0] cur_data;
    logic [1:0]  cur_ch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) credit[i] = CMAX;
        ovf_m    = '0;
        rr       = NUM_CH - 1;
        qd.delete();
        qc.delete();
        cur_val  = 1'b0;
        cur_data = '0;
        cur_ch   = '0;
    endtask

    // One cycle: entered at a falling edge with inputs already driven
    task automatic step();
        int          g;
        logic        acc_ok;
        logic        take;
        logic [2:0]  exp_rdy;
        logic [2:0]  exp_zero;
        logic [63:0] f;
        #1;
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            int i;
            i = (rr + k) % NUM_CH;
            if (g < 0 && in_val[i] && credit[i] > 0) g = i;
        end
        acc_ok  = link_en && (qd.size() == 0);
        exp_rdy = (acc_ok && g >= 0) ? 3'(1 << g) : 3'b000;
        for (int i = 0; i < NUM_CH; i++) exp_zero[i] = (credit[i] == 0);

        chk("in_rdy",       64'(in_rdy),       64'(exp_rdy));
        chk("link_val",     64'(link_val),     64'(cur_val));
        chk("link_data",    64'(link_data),    64'(cur_data));
        chk("link_channel", 64'(link_channel), 64'(cur_ch));
        chk("credit_zero",  64'(credit_zero),  64'(exp_zero));
        chk("credit_ovf",   64'(credit_ovf),   64'(ovf_m));

        for (int i = 0; i < NUM_CH; i++) begin
            take = acc_ok && (g == i);
            if (take && !link_credit[i]) credit[i]--;
            else if (!take && link_credit[i]) begin
                if (credit[i] == CMAX) ovf_m[i] = 1'b1;
                else                   credit[i]++;
            end
        end
        if (acc_ok && g >= 0) begin
            f = in_data[g*FW +: FW];
            for (int b = 0; b < BEATS; b++) begin
                qd.push_back(f[b*PW +: PW]);
                qc.push_back(2'(g));
            end
            rr = g;
        end
        if (qd.size() > 0) begin
            cur_val  = 1'b1;
            cur_data = qd.pop_front();
            cur_ch   = qc.pop_front();
        end else begin
            cur_val  = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock
    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_link_val",    64'(link_val),    64'(0));
        chk("rst_in_rdy",      64'(in_rdy),      64'(0));
        chk("rst_credit_zero", 64'(credit_zero), 64'(0));
        chk("rst_credit_ovf",  64'(credit_ovf),  64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_data();
        in_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        link_en     = 1'b1;
        in_val      = '0;
        in_data     = '0;
        link_credit = '0;
        model_reset();
        @(negedge clk);
        chk("reset_link_val",     64'(link_val),     64'(0));
        chk("reset_link_data",    64'(link_data),    64'(0));
        chk("reset_link_channel", 64'(link_channel), 64'(0));
        chk("reset_in_rdy",       64'(in_rdy),       64'(0));
        chk("reset_credit_zero",  64'(credit_zero),  64'(0));
        chk("reset_credit_ovf",   64'(credit_ovf),   64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single flit on channel 1
        rand_data();
        in_data[FW +: FW] = 64'h1122334455667788;
        in_val = 3'b010;
        step();
        in_val = 3'b000;
        repeat (3) step();

        // All channels continuously valid: fair rotation, no bubbles
        in_val = 3'b111;
        repeat (12) begin
            rand_data();
            step();
        end
        in_val = 3'b000;
        repeat (3) step();

        // Exhaust channel 0 credits, then return exactly one
        reset_mid();
        in_val = 3'b001;
        repeat (2 * CMAX + 6) begin
            rand_data();
            step();
        end
        link_credit = 3'b001;
        step();
        link_credit = 3'b000;
        repeat (6) begin
            rand_data();
            step();
        end
        in_val = 3'b000;
        step();

        // Accept and credit return on ch2 cancel; return on ch0 at max overflows
        reset_mid();
        rand_data();
        in_val      = 3'b100;
        link_credit = 3'b101;
        step();
        in_val      = 3'b000;
        link_credit = 3'b000;
        step();
        link_credit = 3'b100;
        step();
        link_credit = 3'b000;
        repeat (3) step();

        // link_en dropped during beat 0
        reset_mid();
        rand_data();
        in_val  = 3'b001;
        step();
        link_en = 1'b0;
        repeat (5) step();
        link_en = 1'b1;
        step();
        in_val  = 3'b000;
        repeat (3) step();

        // Reset in the middle of a flit, then restart
        rand_data();
        in_val = 3'b010;
        step();
        reset_mid();
        rand_data();
        repeat (4) step();
        in_val = 3'b000;
        repeat (2) step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rand_data();
            in_val      = 3'($urandom());
            link_en     = ($urandom() % 8) != 0;
            link_credit = 3'($urandom() & $urandom());
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
